// File: rtl/lms_weight_seq.sv
// rtl/lms_weight_seq.sv - LMS weight-update sequencer, one shared add/sub across NTAPS weights.
// Optional clamping of overflowing results: define LMS_WSEQ_SAT_EN (default build wraps).
module lms_weight_seq #(
  parameter int NTAPS = 16,
  parameter int W     = 10,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sg,
  input  logic               clr_w,
  output logic               d_req,
  output logic [AW-1:0]      d_addr,
  input  logic [W-1:0]       d_data,
  output logic [NTAPS*W-1:0] w_all,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_idx;
  logic            r_sg;
  logic            r_pv;
  logic [AW-1:0]   r_pidx;
  logic [W-1:0]    r_w [NTAPS];
  logic            r_ovf;

  logic            w_last;
  logic [W-1:0]    w_cur;
  logic [W:0]      w_sum;
  logic            w_of;
  logic [W-1:0]    w_res;

  assign w_last = (r_idx == AW'(NTAPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clr_w) w_next = S_IDLE;
  end

  // Sign-extend both operands so the extra bit exposes overflow of the W-bit weight.
  assign w_cur = r_w[r_pidx];
  assign w_sum = r_sg ? ({w_cur[W-1], w_cur} - {d_data[W-1], d_data})
                      : ({w_cur[W-1], w_cur} + {d_data[W-1], d_data});
  assign w_of  = w_sum[W] ^ w_sum[W-1];

`ifdef LMS_WSEQ_SAT_EN
  always_comb begin
    w_res = w_sum[W-1:0];
    if (w_of) w_res = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign w_res = w_sum[W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_sg   <= 1'b0;
      r_pv   <= 1'b0;
      r_pidx <= '0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) r_w[k] <= '0;
    end else if (clr_w) begin
      r_idx  <= '0;
      r_pv   <= 1'b0;
      r_pidx <= '0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) r_w[k] <= '0;
    end else begin
      // Write pipeline: the tap requested this cycle is written on the next edge.
      r_pv   <= (r_state == S_RUN);
      r_pidx <= r_idx;
      if (r_state == S_IDLE && start) begin
        r_sg  <= sg;
        r_ovf <= 1'b0;
        r_idx <= '0;
      end else if (r_state == S_RUN) begin
        r_idx <= w_last ? '0 : r_idx + AW'(1);
      end
      if (r_pv) begin
        r_w[r_pidx] <= w_res;
        if (w_of) r_ovf <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NTAPS; g++) begin : g_wout
      assign w_all[g*W +: W] = r_w[g];
    end
  endgenerate

  assign d_req  = (r_state == S_RUN);
  assign d_addr = r_idx;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign ovf    = r_ovf;

endmodule
